// File: rtl/ppi_control_logic.sv
// ppi_control_logic
//   Mode-0 control logic for an 8255-style programmable peripheral interface.
//   The CPU strobes are synchronised, then a three-state FSM (IDLE/READ/WRITE)
//   sequences the data bus buffer direction. The block also holds the control
//   word and the port A/B/C output latches.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   cs_n, rd_n, wr_n        CPU chip select / read / write strobes, active low
//   a[1:0]                  register select: 00 PA, 01 PB, 10 PC, 11 control
//   din[7:0]                CPU write data
//   pa_in, pb_in, pc_in     port pin values
//   buf_dir                 1 = buffer drives dout to the CPU
//   dout[7:0]               read data, loaded when a read starts
//   pa_out, pb_out, pc_out  port output latches
//   pa_oe, pb_oe            port A / port B output enables
//   pcu_oe, pcl_oe          port C upper / lower nibble output enables
//   cw[7:0]                 current control word
//   unsup                   one-cycle pulse when a mode-set write is rejected
module ppi_control_logic #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_CW    = 8'h9B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] din,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic       buf_dir,
  output logic [7:0] dout,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic       pa_oe,
  output logic       pb_oe,
  output logic       pcu_oe,
  output logic       pcl_oe,
  output logic [7:0] cw,
  output logic       unsup
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
  logic       cs_s, rd_s, wr_s;
  logic       rd_d, wr_d;
  logic       rd_fall, wr_fall, wr_rise;
  logic       enter_read, leave_read, enter_write, capture, commit;
  logic [1:0] a_q;
  logic [7:0] wdata_q;

  // Read data for a register select, given the current direction bits.
  function automatic logic [7:0] read_mux(
    input logic [1:0] sel,
    input logic [7:0] cwv,
    input logic [7:0] pai, input logic [7:0] pbi, input logic [7:0] pci,
    input logic [7:0] pao, input logic [7:0] pbo, input logic [7:0] pco
  );
    logic [7:0] r;
    case (sel)
      2'b00:   r = cwv[4] ? pai : pao;
      2'b01:   r = cwv[1] ? pbi : pbo;
      2'b10:   r = {cwv[3] ? pci[7:4] : pco[7:4], cwv[0] ? pci[3:0] : pco[3:0]};
      default: r = cwv;
    endcase
    return r;
  endfunction

  // Mode-set words are only accepted for mode 0 on both groups.
  function automatic logic mode0_word(input logic [7:0] d);
    return d[7] && (d[6:5] == 2'b00) && !d[2];
  endfunction

  // ---- strobe synchronisers and edge detect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      rd_d    <= 1'b1;
      wr_d    <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_n};
      rd_d    <= rd_s;
      wr_d    <= wr_s;
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_fall = rd_d & ~rd_s;
  assign wr_fall = wr_d & ~wr_s;
  assign wr_rise = ~wr_d & wr_s;

  // ---- transfer FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    enter_read  = 1'b0;
    leave_read  = 1'b0;
    enter_write = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        // Both strobes low together is ignored: neither edge qualifies.
        if (!cs_s && rd_fall && wr_s) begin
          state_d    = READ;
          enter_read = 1'b1;
        end else if (!cs_s && wr_fall && rd_s) begin
          state_d     = WRITE;
          enter_write = 1'b1;
        end
      end
      READ: begin
        if (rd_s || cs_s) begin
          state_d    = IDLE;
          leave_read = 1'b1;
        end
      end
      WRITE: begin
        // Losing chip select before the strobe ends abandons the write.
        if (cs_s) begin
          state_d = IDLE;
        end else if (wr_rise) begin
          state_d = IDLE;
          commit  = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- bus buffer control, register file and commits ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw      <= RESET_CW;
      pa_out  <= 8'h00;
      pb_out  <= 8'h00;
      pc_out  <= 8'h00;
      dout    <= 8'h00;
      buf_dir <= 1'b0;
      unsup   <= 1'b0;
      a_q     <= 2'b00;
      wdata_q <= 8'h00;
    end else begin
      unsup <= 1'b0;
      if (enter_read) begin
        a_q     <= a;
        dout    <= read_mux(a, cw, pa_in, pb_in, pc_in, pa_out, pb_out, pc_out);
        buf_dir <= 1'b1;
      end
      if (leave_read) buf_dir <= 1'b0;
      if (enter_write) a_q <= a;
      if (enter_write || capture) wdata_q <= din;
      if (commit) begin
        case (a_q)
          2'b00: pa_out <= wdata_q;
          2'b01: pb_out <= wdata_q;
          2'b10: pc_out <= wdata_q;
          default: begin
            if (mode0_word(wdata_q)) begin
              cw     <= wdata_q;
              pa_out <= 8'h00;
              pb_out <= 8'h00;
              pc_out <= 8'h00;
            end else if (wdata_q[7]) begin
              unsup <= 1'b1;
            end else begin
              // Port C bit set/reset.
              pc_out[wdata_q[3:1]] <= wdata_q[0];
            end
          end
        endcase
      end
    end
  end

  assign pa_oe  = ~cw[4];
  assign pb_oe  = ~cw[1];
  assign pcu_oe = ~cw[3];
  assign pcl_oe = ~cw[0];

endmodule

// File: tb/tb_ppi_control_logic.sv
module tb_ppi_control_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] a;
  logic [7:0] din, pa_in, pb_in, pc_in;
  logic       buf_dir;
  logic [7:0] dout, pa_out, pb_out, pc_out, cw;
  logic       pa_oe, pb_oe, pcu_oe, pcl_oe, unsup;

  int checks   = 0;
  int failures = 0;
  int unsup_seen = 0;
  int u0;

  ppi_control_logic #(.SYNC_STAGES(2), .RESET_CW(8'h9B)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a(a), .din(din), .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .buf_dir(buf_dir), .dout(dout), .pa_out(pa_out), .pb_out(pb_out),
    .pc_out(pc_out), .pa_oe(pa_oe), .pb_oe(pb_oe), .pcu_oe(pcu_oe),
    .pcl_oe(pcl_oe), .cw(cw), .unsup(unsup)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (unsup) unsup_seen <= unsup_seen + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    cs_n = 1'b0; a = addr; din = data;
    cycles(1);
    wr_n = 1'b0;
    cycles(6);
    wr_n = 1'b1;
    cycles(5);
    cs_n = 1'b1;
    cycles(3);
  endtask

  task automatic start_read(input logic [1:0] addr);
    @(negedge clk);
    cs_n = 1'b0; a = addr;
    cycles(1);
    rd_n = 1'b0;
    cycles(4);
  endtask

  task automatic end_read();
    rd_n = 1'b1;
    cycles(4);
    cs_n = 1'b1;
    cycles(3);
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 2'b00; din = 8'h00;
    pa_in = 8'hC3; pb_in = 8'h3C; pc_in = 8'h5A;
    cycles(3);
    check("rst_cw", cw, 8'h9B);
    check("rst_buf_dir", {7'b0, buf_dir}, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_pa_out", pa_out, 8'h00);
    check("rst_unsup", {7'b0, unsup}, 8'h00);
    check("rst_oe", {4'b0, pa_oe, pb_oe, pcu_oe, pcl_oe}, 8'h00);
    reset = 1'b0;
    cycles(2);

    // Input-mode reads; dout frozen once the read has started.
    start_read(2'b01);
    check("rd_pb_dir", {7'b0, buf_dir}, 8'h01);
    check("rd_pb", dout, 8'h3C);
    pb_in = 8'h77;
    cycles(3);
    check("rd_pb_hold", dout, 8'h3C);
    end_read();
    check("rd_pb_end_dir", {7'b0, buf_dir}, 8'h00);
    start_read(2'b10);
    check("rd_pc_in", dout, 8'h5A);
    end_read();

    // Mode word then output write and readback.
    u0 = unsup_seen;
    cpu_write(2'b11, 8'h80);
    check("cw_80", cw, 8'h80);
    check("cw_80_nounsup", 8'(unsup_seen - u0), 8'h00);
    cpu_write(2'b00, 8'hA5);
    check("pa_out_a5", pa_out, 8'hA5);
    check("oe_all_out", {4'b0, pa_oe, pb_oe, pcu_oe, pcl_oe}, 8'h0F);
    check("pre_rd_dir", {7'b0, buf_dir}, 8'h00);
    start_read(2'b00);
    check("rd_pa_dir", {7'b0, buf_dir}, 8'h01);
    check("rd_pa_latch", dout, 8'hA5);
    end_read();
    check("rd_pa_end_dir", {7'b0, buf_dir}, 8'h00);

    // Port C bit set/reset.
    cpu_write(2'b11, 8'h0F);
    check("bsr_set7", pc_out, 8'h80);
    check("bsr_cw1", cw, 8'h80);
    cpu_write(2'b11, 8'h0E);
    check("bsr_clr7", pc_out, 8'h00);
    check("bsr_cw2", cw, 8'h80);
    cpu_write(2'b11, 8'h05);
    check("bsr_set2", pc_out, 8'h04);

    // Rejected mode words.
    cpu_write(2'b01, 8'h5A);
    check("pb_out_5a", pb_out, 8'h5A);
    u0 = unsup_seen;
    cpu_write(2'b11, 8'hA0);
    check("rej_a0_pulse", 8'(unsup_seen - u0), 8'h01);
    check("rej_a0_cw", cw, 8'h80);
    check("rej_a0_pa", pa_out, 8'hA5);
    check("rej_a0_pb", pb_out, 8'h5A);
    check("rej_a0_pc", pc_out, 8'h04);
    u0 = unsup_seen;
    cpu_write(2'b11, 8'h84);
    check("rej_84_pulse", 8'(unsup_seen - u0), 8'h01);
    check("rej_84_cw", cw, 8'h80);

    // Write aborted by chip select rising first.
    @(negedge clk);
    cs_n = 1'b0; a = 2'b00; din = 8'h55;
    cycles(1);
    wr_n = 1'b0;
    cycles(6);
    cs_n = 1'b1;
    cycles(5);
    wr_n = 1'b1;
    cycles(5);
    check("abort_pa", pa_out, 8'hA5);

    // Both strobes low together: no transfer.
    @(negedge clk);
    cs_n = 1'b0; a = 2'b00; din = 8'h11;
    cycles(1);
    rd_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check("both_low_dir", {7'b0, buf_dir}, 8'h00);
    end
    rd_n = 1'b1; wr_n = 1'b1;
    cycles(5);
    cs_n = 1'b1;
    cycles(3);
    check("both_low_pa", pa_out, 8'hA5);

    // Reset in the middle of a read.
    start_read(2'b11);
    check("rd_cw", dout, 8'h80);
    check("rd_cw_dir", {7'b0, buf_dir}, 8'h01);
    reset = 1'b1;
    #1;
    check("midrst_dir", {7'b0, buf_dir}, 8'h00);
    check("midrst_cw", cw, 8'h9B);
    check("midrst_pa", pa_out, 8'h00);
    check("midrst_pb", pb_out, 8'h00);
    check("midrst_pc", pc_out, 8'h00);
    cs_n = 1'b1; rd_n = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Latch written even while the port is an input.
    cpu_write(2'b00, 8'h3C);
    check("in_mode_pa_latch", pa_out, 8'h3C);
    check("in_mode_pa_oe", {7'b0, pa_oe}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
